// File: rtl/seg_pkg.sv
// Shared types and seven-segment code constants for the scan controller.
// Codes are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake bundle for the display scan controller.
// Master offers a new 8-digit value; slave accepts when its buffer is empty.
interface seg_scan_ctrl_if;

    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Output bit order is {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with blanking gaps.
// Define SEG_DP_EN to carry per-digit decimal points through to seg[7].
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    seg_scan_ctrl_if.slave  ld,
    output logic [7:0]      an,
    output logic [7:0]      seg,
    output logic            frame_tick
);

    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES)
                        ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic [2:0]    idx;
    logic [2:0]    nxt_idx;

    logic          pend_full;
    logic          nxt_pend_full;
    logic [31:0]   pend_data;
    logic [31:0]   act_data;
    logic [31:0]   nxt_act_data;

    logic          blank_end;
    logic          on_end;
    logic          boundary;
    logic          xfer;
    logic          swap;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic          dp_n;
    logic [7:0]    nxt_an;
    logic [7:0]    nxt_seg;

    assign blank_end = (state == BLANK) && (cnt == BL_LAST);
    assign on_end    = (state == ON) && (cnt == ON_LAST);
    assign boundary  = en && blank_end && (idx == 3'd0);
    assign swap      = boundary && pend_full;

    assign ld.load_ready = !pend_full;
    assign xfer          = ld.load_valid && !pend_full;
    assign frame_tick    = boundary;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CW'(1);
        nxt_idx   = idx;
        unique case (1'b1)
            !en: begin
                nxt_state = BLANK;
                nxt_cnt   = '0;
                nxt_idx   = '0;
            end
            en && blank_end: begin
                nxt_state = ON;
                nxt_cnt   = '0;
            end
            en && on_end: begin
                nxt_state = BLANK;
                nxt_cnt   = '0;
                nxt_idx   = idx + 3'd1;
            end
            default: ;
        endcase
    end

    // A transfer needs an empty buffer, so it never collides with a swap.
    always_comb begin
        nxt_pend_full = pend_full;
        if (swap)
            nxt_pend_full = 1'b0;
        else if (xfer)
            nxt_pend_full = 1'b1;
    end

    assign nxt_act_data = swap ? pend_data : act_data;
    assign nib = nxt_act_data[{nxt_idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nib (nib),
        .seg (dec)
    );

`ifdef SEG_DP_EN
    logic [7:0] pend_dp;
    logic [7:0] act_dp;
    logic [7:0] nxt_act_dp;

    assign nxt_act_dp = swap ? pend_dp : act_dp;
    assign dp_n       = !nxt_act_dp[nxt_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dp <= '0;
            act_dp  <= '0;
        end else begin
            if (xfer)
                pend_dp <= ld.load_dp;
            act_dp <= nxt_act_dp;
        end
    end
`else
    logic unused_dp;
    assign unused_dp = ^ld.load_dp;
    assign dp_n      = 1'b1;
`endif

    // Outputs are built from next-state values so an and seg flip together.
    assign nxt_an  = (nxt_state == ON) ? ~(8'd1 << nxt_idx) : 8'hFF;
    assign nxt_seg = (nxt_state == ON) ? {dp_n, dec} : 8'hFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            act_data  <= '0;
            an        <= 8'hFF;
            seg       <= 8'hFF;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            idx       <= nxt_idx;
            pend_full <= nxt_pend_full;
            if (xfer)
                pend_data <= ld.load_data;
            act_data  <= nxt_act_data;
            an        <= nxt_an;
            seg       <= nxt_seg;
        end
    end

endmodule
